// File: rtl/sd_init_ctrl.sv
// SD card identification/initialisation sequencer: drives the transceiver through
// CMD0, CMD8, CMD55/ACMD41, CMD2, CMD3, CMD7, CMD55/ACMD6, then hands over a 4-bit, fast-clock card.
module sd_init_ctrl #(
    parameter int CMD_RETRIES    = 3,
    parameter int ACMD41_POLLS   = 1000,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        iinit,
    output logic        ostart,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    output logic        osel_clk,
    input  logic        idone,
    input  logic [31:0] iresp,
    input  logic        icrc_fail,
    output logic [15:0] ordca,
    output logic        oready,
    output logic        oerr,
    output logic [2:0]  oerr_code
);

    localparam int RW = $clog2(CMD_RETRIES) + 1;
    localparam int PW = $clog2(ACMD41_POLLS) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [RW-1:0] RETRY_LAST = RW'(CMD_RETRIES - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(ACMD41_POLLS - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_C0, S_C8, S_C55A, S_A41, S_C2, S_C3, S_C7, S_C55B, S_A6, S_READY, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic          send_q, send_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   rca_q, rca_d;
    logic [2:0]    code_q, code_d;

    logic          fail, ok, crc_chk;
    logic [2:0]    fail_code;
    logic          unused_resp;

    assign unused_resp = ^iresp[15:12];

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= S_IDLE;
            send_q  <= 1'b0;
            retry_q <= '0;
            poll_q  <= '0;
            tmo_q   <= '0;
            rca_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            retry_q <= retry_d;
            poll_q  <= poll_d;
            tmo_q   <= tmo_d;
            rca_q   <= rca_d;
            code_q  <= code_d;
        end
    end

    // CMD0 has no response, ACMD41 (R3) and CMD2 (R2) CRCs are not meaningful here
    assign crc_chk = !(state_q inside {S_C0, S_A41, S_C2});

    always_comb begin
        state_d   = state_q;
        send_d    = send_q;
        retry_d   = retry_q;
        poll_d    = poll_q;
        tmo_d     = tmo_q;
        rca_d     = rca_q;
        code_d    = code_q;
        ostart    = 1'b0;
        fail      = 1'b0;
        fail_code = 3'd0;
        ok        = 1'b0;

        case (state_q)
            S_IDLE, S_READY, S_ERROR: begin
                if (iinit) begin
                    state_d = S_C0;
                    send_d  = 1'b1;
                    retry_d = '0;
                    poll_d  = '0;
                    tmo_d   = '0;
                    rca_d   = '0;
                    code_d  = '0;
                end
            end
            default: begin
                if (send_q) begin
                    ostart = 1'b1;
                    send_d = 1'b0;
                    tmo_d  = '0;
                end else if (idone) begin
                    if (icrc_fail && crc_chk) begin
                        fail      = 1'b1;
                        fail_code = 3'd2;
                    end else begin
                        ok = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // cards that stay silent after CMD0 are still allowed to proceed
                    if (state_q == S_C0) begin
                        ok = 1'b1;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 3'd1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        endcase

        if (fail) begin
            send_d = 1'b1;
            tmo_d  = '0;
            if (retry_q >= RETRY_LAST) begin
                state_d = S_ERROR;
                send_d  = 1'b0;
                code_d  = fail_code;
            end else begin
                retry_d = retry_q + RW'(1);
            end
        end

        if (ok) begin
            retry_d = '0;
            tmo_d   = '0;
            send_d  = 1'b1;
            case (state_q)
                S_C0:   state_d = S_C8;
                S_C8: begin
                    if (iresp[11:0] == 12'h1AA) begin
                        state_d = S_C55A;
                    end else begin
                        state_d = S_ERROR;
                        code_d  = 3'd3;
                    end
                end
                S_C55A: state_d = S_A41;
                S_A41: begin
                    if (iresp[31]) begin
                        state_d = S_C2;
                    end else if (poll_q >= POLL_LAST) begin
                        state_d = S_ERROR;
                        code_d  = 3'd4;
                    end else begin
                        poll_d  = poll_q + PW'(1);
                        state_d = S_C55A;
                    end
                end
                S_C2:   state_d = S_C3;
                S_C3: begin
                    rca_d   = iresp[31:16];
                    state_d = S_C7;
                end
                S_C7:   state_d = S_C55B;
                S_C55B: state_d = S_A6;
                S_A6:   state_d = S_READY;
                default: ;
            endcase
            if (state_d inside {S_READY, S_ERROR}) send_d = 1'b0;
        end
    end

    // index/argument decode straight from the state, so they stay stable through WAIT
    always_comb begin
        ocmd_index = 6'd0;
        ocmd_arg   = 32'd0;
        case (state_q)
            S_C8:   begin ocmd_index = 6'd8;  ocmd_arg = 32'h0000_01AA;    end
            S_C55A: begin ocmd_index = 6'd55;                               end
            S_A41:  begin ocmd_index = 6'd41; ocmd_arg = 32'h40FF_8000;    end
            S_C2:   begin ocmd_index = 6'd2;                                end
            S_C3:   begin ocmd_index = 6'd3;                                end
            S_C7:   begin ocmd_index = 6'd7;  ocmd_arg = {rca_q, 16'h0};   end
            S_C55B: begin ocmd_index = 6'd55; ocmd_arg = {rca_q, 16'h0};   end
            S_A6:   begin ocmd_index = 6'd6;  ocmd_arg = 32'h0000_0002;    end
            default: ;
        endcase
    end

    assign osel_clk  = (state_q == S_READY);
    assign oready    = (state_q == S_READY);
    assign oerr      = (state_q == S_ERROR);
    assign oerr_code = code_q;
    assign ordca     = rca_q;

endmodule
